// File: rtl/comms_pkg.sv
// Shared types and constants for the control/data-plane transmit path.
package comms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    STREAM,
    DONE,
    ABORT,
    WAIT_CLR
  } tx_seq_state_t;

  localparam logic [15:0] ALL_ZERO = 16'h0000;
  localparam logic [15:0] ALL_ONE  = 16'hFFFF;

  typedef logic [15:0] node_id_t;

endpackage

// File: rtl/data_tx_sequencer.sv
// Drains one destination header plus payload words from the tx RAM stack and
// drives them as 32-bit data-plane packets once the control plane grants.
module data_tx_sequencer
  import comms_pkg::*;
#(
  parameter int PKT_WORDS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  node_id_t    node_id,
  input  logic        data_tx_flag,
  input  logic [15:0] sp_tx_current,
  input  logic [15:0] RAM_tx_data_out,
  output logic        ram_tx_pop,
  output logic [31:0] data_tx_packet,
  output logic        data_tx_valid,
  output logic        data_tx_complete_flag,
  output logic        busy,
  output logic        underflow_err
);

  localparam int CNT_W = $clog2(PKT_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);

  tx_seq_state_t    r_state,     w_state_next;
  logic [15:0]      r_dest_q,    w_dest_next;
  logic [CNT_W-1:0] r_cnt,       w_cnt_next;
  logic [31:0]      r_packet,    w_packet_next;
  logic             r_valid,     w_valid_next;
  logic             r_pop,       w_pop_next;
  logic             r_complete,  w_complete_next;
  logic             r_underflow, w_underflow_next;
  logic             r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dest_q    <= ALL_ZERO;
      r_cnt       <= '0;
      r_packet    <= '0;
      r_valid     <= 1'b0;
      r_pop       <= 1'b0;
      r_complete  <= 1'b0;
      r_underflow <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dest_q    <= w_dest_next;
      r_cnt       <= w_cnt_next;
      r_packet    <= w_packet_next;
      r_valid     <= w_valid_next;
      r_pop       <= w_pop_next;
      r_complete  <= w_complete_next;
      r_underflow <= w_underflow_next;
      r_busy      <= (w_state_next != IDLE);
    end
  end

  // Outputs are registered: a word decided in HEADER/STREAM appears on the
  // following cycle together with its pop, so the RAM advances exactly once.
  always_comb begin
    w_state_next     = r_state;
    w_dest_next      = r_dest_q;
    w_cnt_next       = r_cnt;
    w_packet_next    = r_packet;
    w_valid_next     = 1'b0;
    w_pop_next       = 1'b0;
    w_complete_next  = 1'b0;
    w_underflow_next = r_underflow;
    case (r_state)
      IDLE: begin
        if (data_tx_flag) begin
          if (sp_tx_current != ALL_ZERO) begin
            w_dest_next  = RAM_tx_data_out;
            w_state_next = HEADER;
          end else begin
            w_state_next = ABORT;
          end
        end
      end
      HEADER: begin
        w_packet_next = {r_dest_q, node_id};
        w_valid_next  = 1'b1;
        w_pop_next    = 1'b1;
        w_cnt_next    = CNT_W'(1);
        w_state_next  = STREAM;
      end
      STREAM: begin
        if (!data_tx_flag) begin
          w_state_next = ABORT;
        end else if (sp_tx_current == ALL_ZERO) begin
          w_underflow_next = 1'b1;
          w_state_next     = ABORT;
        end else begin
          w_packet_next = {r_dest_q, RAM_tx_data_out};
          w_valid_next  = 1'b1;
          w_pop_next    = 1'b1;
          // Counter stops on the last word so it never needs to wrap.
          if (r_cnt == LAST_WORD) begin
            w_state_next = DONE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        w_complete_next = 1'b1;
        w_state_next    = WAIT_CLR;
      end
      ABORT: begin
        w_complete_next = 1'b1;
        w_state_next    = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!data_tx_flag) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign ram_tx_pop            = r_pop;
  assign data_tx_packet        = r_packet;
  assign data_tx_valid         = r_valid;
  assign data_tx_complete_flag = r_complete;
  assign busy                  = r_busy;
  assign underflow_err         = r_underflow;

endmodule

// File: tb/tb_data_tx_sequencer.sv
// Directed/randomized bench for data_tx_sequencer with a queue-based tx RAM
// stack and a transfer-level expectation model.
module tb_data_tx_sequencer;
  import comms_pkg::*;

  localparam int PKT_WORDS = 5;

  logic        clk = 1'b0;
  logic        rst;
  node_id_t    node_id;
  logic        data_tx_flag;
  logic [15:0] sp_tx_current;
  logic [15:0] RAM_tx_data_out;
  logic        ram_tx_pop;
  logic [31:0] data_tx_packet;
  logic        data_tx_valid;
  logic        data_tx_complete_flag;
  logic        busy;
  logic        underflow_err;

  data_tx_sequencer #(.PKT_WORDS(PKT_WORDS)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .node_id               (node_id),
    .data_tx_flag          (data_tx_flag),
    .sp_tx_current         (sp_tx_current),
    .RAM_tx_data_out       (RAM_tx_data_out),
    .ram_tx_pop            (ram_tx_pop),
    .data_tx_packet        (data_tx_packet),
    .data_tx_valid         (data_tx_valid),
    .data_tx_complete_flag (data_tx_complete_flag),
    .busy                  (busy),
    .underflow_err         (underflow_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pop_cnt;
  logic        uf_model;
  logic [15:0] stack[$];
  logic [15:0] words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stack model: top of stack is the back of the queue.
  task automatic refresh();
    sp_tx_current = 16'(stack.size());
    if (stack.size() > 0) RAM_tx_data_out = stack[stack.size()-1];
    else                  RAM_tx_data_out = 16'($urandom);
  endtask

  task automatic load_stack();
    stack.delete();
    for (int i = words.size() - 1; i >= 0; i--) stack.push_back(words[i]);
    refresh();
  endtask

  // The RAM pops on the same edge the registered pop appears.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ram_tx_pop) begin
      pop_cnt++;
      if (stack.size() > 0) void'(stack.pop_back());
    end
    refresh();
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  task automatic run_xfer(input string tag, input int drop_after);
    int n, exp_n, got, comps;
    logic exp_uf;
    logic [31:0] exp_pkt;
    n = words.size();
    load_stack();
    pop_cnt = 0;
    if (drop_after >= 0) exp_n = drop_after;
    else                 exp_n = (n < PKT_WORDS) ? n : PKT_WORDS;
    exp_uf   = (drop_after < 0) && (n > 0) && (n < PKT_WORDS);
    uf_model = uf_model | exp_uf;
    got   = 0;
    comps = 0;
    data_tx_flag = 1'b1;
    for (int c = 0; c < 40 && comps == 0; c++) begin
      tick();
      check({tag, " pop_eq_valid"}, {31'd0, ram_tx_pop}, {31'd0, data_tx_valid});
      if (data_tx_valid) begin
        if (got < exp_n) begin
          exp_pkt = {words[0], (got == 0) ? node_id : words[got]};
          check($sformatf("%s pkt%0d", tag, got), data_tx_packet, exp_pkt);
        end
        got++;
        if (got == drop_after) data_tx_flag = 1'b0;
      end
      if (data_tx_complete_flag) comps++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (data_tx_valid) got++;
      if (data_tx_complete_flag) comps++;
    end
    check({tag, " words"},     got,     exp_n);
    check({tag, " pops"},      pop_cnt, exp_n);
    check({tag, " completes"}, comps,   1);
    check({tag, " underflow"}, {31'd0, underflow_err}, {31'd0, uf_model});
    check({tag, " busy"},      {31'd0, busy}, {31'd0, data_tx_flag});
    $display("xfer %s: stack=%0d words=%0d pops=%0d completes=%0d underflow=%b",
             tag, n, got, pop_cnt, comps, underflow_err);
  endtask

  task automatic release_grant(input string tag);
    data_tx_flag = 1'b0;
    tick();
    check({tag, " busy_after_release"}, {31'd0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    int got, vcnt;
    rst          = 1'b1;
    uf_model     = 1'b0;
    pop_cnt      = 0;
    node_id      = 16'($urandom);
    data_tx_flag = 1'($urandom);
    stack.delete();
    refresh();
    sp_tx_current   = 16'($urandom);
    RAM_tx_data_out = 16'($urandom);
    tick();
    tick();
    check("rst valid",    {31'd0, data_tx_valid},         32'd0);
    check("rst pop",      {31'd0, ram_tx_pop},            32'd0);
    check("rst packet",   data_tx_packet,                 32'd0);
    check("rst complete", {31'd0, data_tx_complete_flag}, 32'd0);
    check("rst busy",     {31'd0, busy},                  32'd0);
    check("rst underflow",{31'd0, underflow_err},         32'd0);
    $display("reset: outputs valid=%b pop=%b busy=%b", data_tx_valid, ram_tx_pop, busy);
    rst = 1'b0;
    data_tx_flag = 1'b0;
    refresh();
    tick();

    // Directed normal transfer.
    node_id = 16'h0002;
    words.delete();
    words.push_back(16'h0003);
    words.push_back(16'h00A1);
    words.push_back(16'h00A2);
    words.push_back(16'h00A3);
    words.push_back(16'h00A4);
    run_xfer("normal", -1);
    release_grant("normal");

    // Deeper stack than one packet: only PKT_WORDS leave.
    node_id = 16'($urandom);
    fill_words(8);
    run_xfer("deep_stack", -1);
    check("deep_stack left", stack.size(), 3);
    release_grant("deep_stack");

    // Exactly PKT_WORDS: stack empties on the final pop without underflow.
    fill_words(PKT_WORDS);
    run_xfer("exact", -1);
    check("exact left", stack.size(), 0);
    release_grant("exact");

    // Grant withdrawn after header and one payload word.
    fill_words(PKT_WORDS);
    run_xfer("withdrawn", 2);
    release_grant("withdrawn");

    // Empty stack at grant: abort, no underflow.
    words.delete();
    run_xfer("empty", -1);
    release_grant("empty");

    // Underflow mid-transfer.
    node_id = 16'($urandom);
    fill_words(3);
    run_xfer("underflow", -1);
    release_grant("underflow");

    // Sticky error persists across a clean transfer.
    fill_words(PKT_WORDS);
    run_xfer("after_uf", -1);
    release_grant("after_uf");

    // Asynchronous reset during word 2.
    fill_words(PKT_WORDS);
    load_stack();
    pop_cnt = 0;
    got = 0;
    data_tx_flag = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      tick();
      if (data_tx_valid) got++;
    end
    check("areset reached word2", got, 3);
    #2 rst = 1'b1;
    #1;
    check("areset valid",     {31'd0, data_tx_valid},         32'd0);
    check("areset pop",       {31'd0, ram_tx_pop},            32'd0);
    check("areset packet",    data_tx_packet,                 32'd0);
    check("areset busy",      {31'd0, busy},                  32'd0);
    check("areset complete",  {31'd0, data_tx_complete_flag}, 32'd0);
    check("areset underflow", {31'd0, underflow_err},         32'd0);
    $display("async reset: valid=%b busy=%b underflow=%b", data_tx_valid, busy, underflow_err);
    uf_model = 1'b0;
    data_tx_flag = 1'b0;
    #1 rst = 1'b0;
    tick();
    fill_words(PKT_WORDS);
    run_xfer("post_reset", -1);

    // Sticky grant: flag stays high, stack refilled, nothing restarts.
    fill_words(PKT_WORDS);
    load_stack();
    pop_cnt = 0;
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (data_tx_valid) vcnt++;
    end
    check("sticky valids", vcnt,    0);
    check("sticky pops",   pop_cnt, 0);
    check("sticky busy",   {31'd0, busy}, 32'd1);
    $display("sticky grant: valids=%0d pops=%0d busy=%b", vcnt, pop_cnt, busy);
    data_tx_flag = 1'b0;
    tick();
    check("sticky release busy", {31'd0, busy}, 32'd0);
    fill_words(PKT_WORDS);
    run_xfer("regrant", -1);
    release_grant("regrant");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_tx_sequencer.md
Name: data_tx_sequencer

Overview:
Sequences the data-plane transmitter once the control plane has won a ping handshake (data_tx_flag high). Pops one destination header plus payload words from the tx RAM stack and drives them as 32-bit data-plane packets. Returns data_tx_complete_flag to the control plane so it can release data_tx_flag. Sits between the control plane, the tx RAM and the data-plane transceiver.

Parameters:
PKT_WORDS, 5, total words per transfer including the destination header word; legal values are 2 and above.
CNT_W, $clog2(PKT_WORDS), width of the word counter (derived, not overridden).

Ports:
clk  in  1  system clock.
rst  in  1  reset; one clock domain, asynchronous, active-high.
node_id  in  16  this node's id (shortint-compatible).
data_tx_flag  in  1  grant from the control plane; stays high until complete is seen.
sp_tx_current  in  16  tx RAM stack pointer; 0 means empty.
RAM_tx_data_out  in  16  top-of-stack word of the tx RAM.
ram_tx_pop  out  1  pop request; the tx RAM decrements sp and presents the new top on the same edge it samples pop, so back-to-back pops are legal.
data_tx_packet  out  32  packet on the data plane.
data_tx_valid  out  1  data_tx_packet is valid this cycle.
data_tx_complete_flag  out  1  one-cycle pulse at the end of a transfer or an abort.
busy  out  1  high in every state except IDLE.
underflow_err  out  1  sticky; stack emptied mid-transfer; cleared only by rst.

Behaviour:
- Reset: all outputs 0, dest_q = 0, cnt = 0, state = IDLE. rst is asynchronous, so outputs clear without a clock edge, including in the middle of a transfer.
- All outputs are registered. The pop, packet and valid outputs for a word change on the same edge.
- IDLE:
  - If data_tx_flag and sp_tx_current != 0: latch dest_q = RAM_tx_data_out, go to HEADER.
  - If data_tx_flag and sp_tx_current == 0: go to ABORT without setting underflow_err (there is nothing to send).
- HEADER, one cycle:
  - packet = {dest_q, node_id}, valid = 1, pop = 1, cnt = 1.
  - Next state is STREAM.
- STREAM, one word per cycle:
  - If data_tx_flag == 0: go to ABORT. Nothing is emitted or popped that cycle.
  - Else if sp_tx_current == 0: go to ABORT and set underflow_err.
  - Else: packet = {dest_q, RAM_tx_data_out}, valid = 1, pop = 1, cnt++.
  - When the word just sent is word PKT_WORDS-1: go to DONE.
- DONE: complete = 1 for exactly one cycle, valid = 0, pop = 0. Next state is WAIT_CLR.
- ABORT: complete = 1 for exactly one cycle, so the control plane drops its grant. Next state is WAIT_CLR.
- WAIT_CLR: hold until data_tx_flag == 0, then go to IDLE.
  - A flag held high never retriggers a transfer.
  - A new transfer needs a fresh grant after IDLE.
- Pops per transfer:
  - Normal transfer: exactly PKT_WORDS.
  - Abort: the number of words already emitted.
- sp reaching 0 exactly on the final pop is a normal completion, not an underflow.
- valid and pop are never both high outside HEADER and STREAM.
- Counter width is CNT_W. It never wraps, because a transfer terminates at PKT_WORDS-1.

Decomposition:
- Shared package comms_pkg holds:
  - state enum tx_seq_state_t {IDLE, HEADER, STREAM, DONE, ABORT, WAIT_CLR};
  - constants ALL_ZERO = 16'h0000 and ALL_ONE = 16'hFFFF;
  - typedef node_id_t (16-bit).
- Single module, no sub-module. The FSM, counter and output registers fit in one always_ff plus next-state always_comb.

Test Plan:
1. Reset: assert rst for 2 cycles with random inputs -> every output is 0 and busy = 0.
2. Normal transfer: node_id = 0x0002, stack holds 0x0003,0xA1,0xA2,0xA3,0xA4 (sp = 5), raise data_tx_flag -> packets {0003,0002},{0003,00A1},{0003,00A2},{0003,00A3},{0003,00A4} on 5 consecutive valid cycles with 5 pops. complete pulses on the next cycle. busy drops one cycle after data_tx_flag is released.
3. Underflow: sp = 3, PKT_WORDS = 5 -> header plus 2 payload words and 3 pops, then ABORT. underflow_err = 1 and complete pulses once.
4. Grant withdrawn: drop data_tx_flag after the header and 1 payload word -> no further valid or pop. complete pulses and underflow_err stays 0.
5. Async reset mid-STREAM: pulse rst between clock edges during word 2 -> outputs go to 0 immediately. State is IDLE and the next grant starts with a HEADER.
6. Sticky grant: keep data_tx_flag high for 20 cycles after complete with sp = 5 -> no new header. Drop the flag for 1 cycle then raise it -> a new transfer starts.
